// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO drain UART transmitter.
// Holds the frame state encoding and the baud counter width.
package fifo_tx_pkg;

  localparam int DEFAULT_DATA_W = 4;
  localparam int CNT_W          = $clog2(256);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // True while the serial line carries frame bits, i.e. the baud counter must run.
  function automatic logic line_active(input state_e s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage

// File: rtl/fifo_drain_uart_tx_if.sv
// FIFO read-port bundle between the drain engine (master) and the FIFO (slave).
interface fifo_drain_uart_tx_if
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/fifo_tx_baud_gen.sv
// Bit-period counter: held at zero by restart, wraps and flags bit_end
// on the last clock of each serial bit.
module fifo_tx_baud_gen
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST_CNT);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: reset is synchronous here, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_drain_uart_tx.sv
// Drain engine: pops one FIFO word whenever enabled and non-empty, and sends it
// as start, LSB-first data, optional even parity and stop bits on tx.
module fifo_drain_uart_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  fifo_drain_uart_tx_if.master         fifo_if,
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;

  logic bit_end;
  logic baud_restart;
  logic rd_en;

  fifo_tx_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (baud_restart),
    .bit_end (bit_end)
  );

  assign baud_restart      = !line_active(state_q);
  assign fifo_if.fifo_rd_en = rd_en;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ena && !fifo_if.fifo_empty) state_d = POP;
      POP:     state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_idx_q == LAST_IDX)) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    busy       = 1'b1;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      POP:     rd_en = 1'b1;
      LOAD:    tx = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      PARITY:  tx = parity_q;
      STOP:    frame_done = bit_end;
      default: busy = 1'b0;
    endcase
  end

  // Read data is only trusted in LOAD, one cycle after the pop strobe.
  always_comb begin
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    if (state_q == LOAD) begin
      shift_d   = fifo_if.fifo_rd_data;
      parity_d  = ^fifo_if.fifo_rd_data;
      bit_idx_d = '0;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_uart_tx.sv
// Scoreboard bench: stimulus queues FIFO words and their hand-computed frames;
// monitors check every tx cycle, pop strobes and frame timing against them.
module tb_fifo_drain_uart_tx;

  typedef struct {
    logic [7:0] bits;    // bits[k] = k-th serial bit (start first)
    int         nb;      // number of serial bits in the frame
    bit         gap_chk; // frame must follow the previous one back-to-back
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ena_a, ena_b;

  logic       tx_v      [2];
  logic       busy_v    [2];
  logic       fd_v      [2];
  logic       rd_en_v   [2];
  logic       empty_v   [2] = '{1'b1, 1'b1};
  logic [3:0] rd_data_v [2] = '{4'h0, 4'h0};

  exp_t       exp_a[$], exp_b[$];
  logic [3:0] fifo_a[$], fifo_b[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int pop_cnt  [2] = '{0, 0};
  int pop_cyc  [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};
  int abort_cnt[2] = '{0, 0};

  fifo_drain_uart_tx_if #(.DATA_W(4)) ifa ();
  fifo_drain_uart_tx_if #(.DATA_W(4)) ifb ();

  assign ifa.fifo_empty   = empty_v[0];
  assign ifa.fifo_rd_data = rd_data_v[0];
  assign rd_en_v[0]       = ifa.fifo_rd_en;
  assign ifb.fifo_empty   = empty_v[1];
  assign ifb.fifo_rd_data = rd_data_v[1];
  assign rd_en_v[1]       = ifb.fifo_rd_en;

  fifo_drain_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena_a),
    .fifo_if    (ifa),
    .tx         (tx_v[0]),
    .busy       (busy_v[0]),
    .frame_done (fd_v[0])
  );

  fifo_drain_uart_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena_b),
    .fifo_if    (ifb),
    .tx         (tx_v[1]),
    .busy       (busy_v[1]),
    .frame_done (fd_v[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic int exp_size(input int g);
    return (g == 0) ? exp_a.size() : exp_b.size();
  endfunction

  function automatic int fifo_size(input int g);
    return (g == 0) ? fifo_a.size() : fifo_b.size();
  endfunction

  // FIFO stub: hands out the front word on a pop and keeps the empty flag current.
  task automatic fifo_model(input int g);
    logic prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && rd_en_v[g] === 1'b1) begin
        check($sformatf("pop_busy[%0d]", g), busy_v[g], 1);
        check($sformatf("pop_single_cycle[%0d]", g), prev_rd, 0);
        check($sformatf("pop_nonempty[%0d]", g), fifo_size(g) > 0, 1);
        if (fifo_size(g) > 0) rd_data_v[g] = (g == 0) ? fifo_a.pop_front() : fifo_b.pop_front();
        pop_cnt[g]++;
        pop_cyc[g] = cyc;
      end
      prev_rd    = rd_en_v[g];
      empty_v[g] = (fifo_size(g) == 0);
    end
  endtask

  // Frame monitor: on a start bit, pops the expected frame and checks every cycle of it.
  task automatic frame_mon(input int g);
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (tx_v[g] !== 1'b0) begin
        check($sformatf("idle_frame_done[%0d]", g), fd_v[g], 0);
        continue;
      end
      check($sformatf("expected_frame_queued[%0d]", g), exp_size(g) > 0, 1);
      if (exp_size(g) == 0) continue;
      e = (g == 0) ? exp_a.pop_front() : exp_b.pop_front();
      check($sformatf("pop_to_start[%0d]", g), cyc - pop_cyc[g], 2);
      if (e.gap_chk) check($sformatf("inter_frame_gap[%0d]", g), cyc - done_cyc[g], 4);
      for (int k = 0; k < e.nb * 4; k++) begin
        if (k > 0) @(negedge clk);
        if (!rst_n) begin
          abort_cnt[g]++;
          break;
        end
        check($sformatf("tx_bit%0d[%0d]", k / 4, g), tx_v[g], e.bits[k/4]);
        check($sformatf("busy_in_frame[%0d]", g), busy_v[g], 1);
        check($sformatf("frame_done_c%0d[%0d]", k + 1, g), fd_v[g], (k == e.nb * 4 - 1) ? 1 : 0);
        if (fd_v[g] === 1'b1) done_cyc[g] = cyc;
      end
    end
  endtask

  task automatic push_a(input logic [3:0] w, input logic [7:0] bits, input bit gap, input bit expect_frame);
    fifo_a.push_back(w);
    if (expect_frame) exp_a.push_back('{bits: bits, nb: 7, gap_chk: gap});
  endtask

  task automatic wait_done(input int g, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_size(g) == 0 && busy_v[g] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_tx_fall(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int pops_before;
    rst_n = 1'b0;
    ena_a = 1'b1;
    ena_b = 1'b1;
    fork
      fifo_model(0);
      fifo_model(1);
      frame_mon(0);
      frame_mon(1);
    join_none

    // Reset held with a word waiting: line idle, no pop; pop one cycle after release.
    push_a(4'b1010, 8'b0101_0100, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx_v[0], 1);
      check("rst_rd_en", rd_en_v[0], 0);
      check("rst_busy", busy_v[0], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_pop_after_release", rd_en_v[0], 1);
    wait_done(0, 200, "done_single_1010");
    check("pops_single", pop_cnt[0], 1);

    // 4'b0111 with and without the parity bit.
    @(posedge clk); #1;
    push_a(4'b0111, 8'b0110_1110, 1'b0, 1'b1);
    fifo_b.push_back(4'b0111);
    exp_b.push_back('{bits: 8'b0010_1110, nb: 6, gap_chk: 1'b0});
    wait_done(0, 200, "done_0111_parity");
    wait_done(1, 200, "done_0111_noparity");
    check("pops_0111_a", pop_cnt[0], 2);
    check("pops_0111_b", pop_cnt[1], 1);

    // Two queued words go out back-to-back.
    @(posedge clk); #1;
    push_a(4'b1010, 8'b0101_0100, 1'b0, 1'b1);
    push_a(4'b1100, 8'b0101_1000, 1'b1, 1'b1);
    wait_done(0, 300, "done_back_to_back");
    check("pops_back_to_back", pop_cnt[0], 4);

    // ena dropped during DATA: frame finishes, second word stays in the FIFO.
    @(posedge clk); #1;
    pops_before = pop_cnt[0];
    push_a(4'b0011, 8'b0100_0110, 1'b0, 1'b1);
    push_a(4'b0101, 8'b0000_0000, 1'b0, 1'b0);
    wait_tx_fall(50, "ena_drop_start_seen");
    repeat (8) @(negedge clk);
    @(posedge clk); #1 ena_a = 1'b0;
    wait_done(0, 200, "done_ena_drop");
    repeat (20) @(negedge clk);
    check("ena_drop_pops", pop_cnt[0] - pops_before, 1);
    check("ena_drop_busy", busy_v[0], 0);
    check("ena_drop_fifo_left", fifo_a.size(), 1);
    fifo_a.delete();
    @(negedge clk);
    @(posedge clk); #1 ena_a = 1'b1;

    // Reset during PARITY of a 0011 frame (parity bit 0): line high, no retry.
    pops_before = pop_cnt[0];
    push_a(4'b0011, 8'b0100_0110, 1'b0, 1'b1);
    wait_tx_fall(50, "rst_parity_start_seen");
    repeat (21) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_tx", tx_v[0], 1);
    check("rst_mid_busy", busy_v[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_mid_no_retry_pop", pop_cnt[0] - pops_before, 1);
    check("rst_mid_aborted", abort_cnt[0], 1);
    check("rst_mid_idle_tx", tx_v[0], 1);
    check("rst_mid_idle_busy", busy_v[0], 0);
    check("b_pops_total", pop_cnt[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
